reg_shift_sequencer: RTL

Multi-cycle controller for ARM register-specified shifts (`shiftOperand[4]=1`, non-immediate, non-memory data-processing instructions), which the single-cycle operand generator does not handle. It stalls the decode stage and fetches Rs through the shared register-file read port via a request/grant handshake. It then applies the shift to the latched Rm value and returns the shifted operand and shifter carry-out to the EXE-stage operand mux.

---
 rtl/reg_shift_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/reg_shift_sequencer.sv
// reg_shift_sequencer: multi-cycle controller for ARM register-specified shifts.
// It stalls decode and fetches Rs through the shared register-file read port.
// The shift is applied to the captured Rm value, and the shifted operand and
// shifter carry-out are returned for one cycle.
module reg_shift_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [11:0] shiftOperand,
    input  logic [31:0] valRm,
    input  logic        carryIn,
    output logic        rfReq,
    output logic [3:0]  rfAddr,
    input  logic        rfGrant,
    input  logic [31:0] rfData,
    output logic        stall,
    output logic        done,
    output logic [31:0] valOut,
    output logic        carryOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    state_t      state_q, state_d;
    logic [3:0]  rs_idx_q;
    shift_t      type_q;
    logic [31:0] rm_q;
    logic        cin_q;

    logic        capture;
    logic        req_active;
    logic        finish;

    // Operand sources: live decode inputs in the capture cycle, latched copies afterwards.
    shift_t      sh_type;
    logic [31:0] sh_v;
    logic        sh_c;
    logic [7:0]  sh_n;

    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_w;
    logic [5:0]         asr_amt;
    logic [4:0]         ror_amt;
    logic [31:0]        ror_v;
    logic [31:0]        shift_val;
    logic               shift_c;

    // Only Rs[7:0] sets the amount; Rm index and the immediate-form bits are not used here.
    logic unused_inputs;
    assign unused_inputs = ^{rfData[31:8], shiftOperand[7], shiftOperand[4:0]};

    assign capture    = (state_q == S_IDLE) && start && !flush;
    assign req_active = capture || ((state_q == S_REQ) && !flush);
    assign finish     = req_active && rfGrant;

    assign rfReq  = req_active;
    assign stall  = req_active;
    assign rfAddr = (state_q == S_IDLE) ? shiftOperand[11:8] : rs_idx_q;
    assign done   = (state_q == S_DONE) && !flush;

    // Select operands: bypass the not-yet-latched inputs when the grant comes in the start cycle.
    always_comb begin
        if (state_q == S_IDLE) begin
            sh_type = shift_t'(shiftOperand[6:5]);
            sh_v    = valRm;
            sh_c    = carryIn;
        end else begin
            sh_type = type_q;
            sh_v    = rm_q;
            sh_c    = cin_q;
        end
        sh_n = rfData[7:0];
    end

    // Barrel shift with amounts up to 255; 33-bit intermediates carry the shifted-out bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        shift_val = sh_v;
        shift_c   = sh_c;
        lsl_w     = {1'b0, sh_v} << sh_n;
        lsr_w     = {sh_v, 1'b0} >> sh_n;
        asr_amt   = (sh_n > 8'd31) ? 6'd32 : {1'b0, sh_n[4:0]};
        asr_w     = $signed({sh_v, 1'b0}) >>> asr_amt;
        ror_amt   = sh_n[4:0];
        ror_v     = (sh_v >> ror_amt) | (sh_v << (6'd32 - {1'b0, ror_amt}));
        if (sh_n != 8'd0) begin
            case (sh_type)
                SH_LSL: begin
                    shift_val = lsl_w[31:0];
                    shift_c   = lsl_w[32];
                end
                SH_LSR: begin
                    shift_val = lsr_w[32:1];
                    shift_c   = lsr_w[0];
                end
                SH_ASR: begin
                    shift_val = asr_w[32:1];
                    shift_c   = asr_w[0];
                end
                default: begin
                    shift_val = ror_v;
                    shift_c   = ror_v[31];
                end
            endcase
        end
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (capture) state_d = rfGrant ? S_DONE : S_REQ;
                S_REQ:   if (rfGrant) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Latch the instruction fields and operands on capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_idx_q <= 4'd0;
            type_q   <= SH_LSL;
            rm_q     <= 32'd0;
            cin_q    <= 1'b0;
        end else if (capture) begin
            rs_idx_q <= shiftOperand[11:8];
            type_q   <= shift_t'(shiftOperand[6:5]);
            rm_q     <= valRm;
            cin_q    <= carryIn;
        end
    end

    // Result registers load on the edge entering DONE and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valOut   <= 32'd0;
            carryOut <= 1'b0;
        end else if (finish) begin
            valOut   <= shift_val;
            carryOut <= shift_c;
        end
    end

endmodule
